// File: rtl/fifo_pkg.sv
// Shared defaults, derived widths and types for the chip-select synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 16;
    localparam int unsigned PTR_W          = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W          = PTR_W + 1;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Bit order {write accepted, read accepted} so the pair casts straight in.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_cs_if.sv
// Write/read port bundle of sync_fifo_cs; master drives requests, slave is the FIFO.
interface sync_fifo_cs_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  i_wr_cs;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_data_in;
    logic                  i_rd_cs;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] o_data_out;
    logic                  o_full;
    logic                  o_empty;
    logic [CW-1:0]         o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_wr_cs, i_wr_en, i_data_in, i_rd_cs, i_rd_en,
        input  o_data_out, o_full, o_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_cs, i_wr_en, i_data_in, i_rd_cs, i_rd_en,
        output o_data_out, o_full, o_empty, o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, registered read port, no reset.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_cs.sv
// Synchronous FIFO with chip-selected write/read ports, occupancy count and
// one-cycle overflow/underflow pulses. Storage lives in fifo_mem.
module sync_fifo_cs
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sync_fifo_cs_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_valid_q, rd_valid_d;

    logic                  wr_req, rd_req;
    logic                  wr_accept, rd_accept;
    logic                  full, empty;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    fifo_op_e              op;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign wr_req = bus.i_wr_cs & bus.i_wr_en;
    assign rd_req = bus.i_rd_cs & bus.i_rd_en;

    // Gating with i_rst keeps the array untouched while reset is held.
    assign wr_accept = wr_req & ~full  & ~i_rst;
    assign rd_accept = rd_req & ~empty & ~i_rst;

    always_comb begin
        op          = fifo_op_e'({wr_accept, rd_accept});
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_req & full;
        underflow_d = rd_req & empty;
        rd_valid_d  = rd_valid_q | rd_accept;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (op)
            OP_WR:   count_d = count_q + CW'(1);
            OP_RD:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.i_data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    // The array has no reset, so output data reads as zero until the first
    // accepted read after reset has reloaded the read register.
    assign bus.o_data_out  = rd_valid_q ? mem_rd_data : '0;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_count     = count_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_cs.sv
// Directed self-checking bench for sync_fifo_cs (DATA_WIDTH=8, DEPTH=16).
module tb_sync_fifo_cs;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_cs_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    sync_fifo_cs #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_in(input logic wcs, input logic we, input logic [7:0] d,
                          input logic rcs, input logic re);
        bus.i_wr_cs   = wcs;
        bus.i_wr_en   = we;
        bus.i_data_in = d;
        bus.i_rd_cs   = rcs;
        bus.i_rd_en   = re;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [7:0] d);
        set_in(1'b1, 1'b1, d, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_rd();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_rw(input logic [7:0] d);
        set_in(1'b1, 1'b1, d, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] sword(input int i);
        return 8'((i * 7 + 3) & 8'hFF);
    endfunction

    initial begin
        logic [7:0] tbl [3];
        tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33;
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state while i_rst is held
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        check("rst_full", 32'(bus.o_full), 32'd0);
        check("rst_data", 32'(bus.o_data_out), 32'h00);
        check("rst_ovf", 32'(bus.o_overflow), 32'd0);
        check("rst_unf", 32'(bus.o_underflow), 32'd0);
        rst = 1'b0;
        tick();

        // Basic write 3 / read 3
        for (int i = 0; i < 3; i++) do_wr(tbl[i]);
        check("basic_count3", 32'(bus.o_count), 32'd3);
        check("basic_empty0", 32'(bus.o_empty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_rd();
            check($sformatf("basic_rd%0d", i), 32'(bus.o_data_out), 32'(tbl[i]));
        end
        check("basic_empty1", 32'(bus.o_empty), 32'd1);

        // Underflow pulse, data held
        do_rd();
        check("unf_pulse", 32'(bus.o_underflow), 32'd1);
        check("unf_data_hold", 32'(bus.o_data_out), 32'h33);
        check("unf_count", 32'(bus.o_count), 32'd0);
        tick();
        check("unf_clear", 32'(bus.o_underflow), 32'd0);
        check("unf_data_hold2", 32'(bus.o_data_out), 32'h33);

        // Chip selects low: no effect, no flag
        set_in(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("cs_count", 32'(bus.o_count), 32'd0);
        check("cs_ovf", 32'(bus.o_overflow), 32'd0);
        check("cs_unf", 32'(bus.o_underflow), 32'd0);

        // Fill to 16, then overflow
        for (int i = 0; i < 16; i++) do_wr(8'(8'hA0 + i));
        check("fill_count", 32'(bus.o_count), 32'd16);
        check("fill_full", 32'(bus.o_full), 32'd1);
        do_wr(8'hFF);
        check("ovf_pulse", 32'(bus.o_overflow), 32'd1);
        check("ovf_count", 32'(bus.o_count), 32'd16);
        tick();
        check("ovf_clear", 32'(bus.o_overflow), 32'd0);

        // Full + read/write: read wins, overflow pulses
        do_rw(8'hEE);
        check("fullrw_count", 32'(bus.o_count), 32'd15);
        check("fullrw_data", 32'(bus.o_data_out), 32'hA0);
        check("fullrw_ovf", 32'(bus.o_overflow), 32'd1);
        check("fullrw_notfull", 32'(bus.o_full), 32'd0);
        for (int i = 1; i < 8; i++) do_rd();
        check("mid_data", 32'(bus.o_data_out), 32'hA7);
        check("mid_count8", 32'(bus.o_count), 32'd8);
        do_rw(8'hBB);
        check("midrw_count", 32'(bus.o_count), 32'd8);
        check("midrw_data", 32'(bus.o_data_out), 32'hA8);
        for (int i = 9; i < 16; i++) do_rd();
        check("drain_a_f", 32'(bus.o_data_out), 32'hAF);
        do_rd();
        check("drain_bb", 32'(bus.o_data_out), 32'hBB);
        check("drain_empty", 32'(bus.o_empty), 32'd1);

        // 40-word stream across pointer wrap, five words in flight
        for (int i = 0; i < 5; i++) do_wr(sword(i));
        for (int i = 5; i < 40; i++) begin
            do_rw(sword(i));
            check($sformatf("stream_d%0d", i - 5), 32'(bus.o_data_out), 32'(sword(i - 5)));
            check($sformatf("stream_c%0d", i - 5), 32'(bus.o_count), 32'd5);
        end
        for (int i = 35; i < 40; i++) begin
            do_rd();
            check($sformatf("stream_d%0d", i), 32'(bus.o_data_out), 32'(sword(i)));
        end
        check("stream_empty", 32'(bus.o_empty), 32'd1);

        // Asynchronous reset at count 5, seen before the next edge
        for (int i = 0; i < 5; i++) do_wr(8'(8'h60 + i));
        check("arst_pre_count", 32'(bus.o_count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.o_count), 32'd0);
        check("arst_empty", 32'(bus.o_empty), 32'd1);
        check("arst_data", 32'(bus.o_data_out), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        do_rd();
        check("arst_unf", 32'(bus.o_underflow), 32'd1);
        check("arst_data_hold", 32'(bus.o_data_out), 32'h00);
        do_wr(8'h5A);
        check("post_count", 32'(bus.o_count), 32'd1);
        do_rd();
        check("post_data", 32'(bus.o_data_out), 32'h5A);
        check("post_empty", 32'(bus.o_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
